vx_mem_line_bridge: RTL and testbench

VX_MEM_LINE_BRIDGE -- requirements
Module: vx_mem_line_bridge

---
 rtl/vx_mem_line_bridge_if.sv | 44 ++++
 rtl/vx_mem_line_bridge.sv | 170 +++++++++++++++++
 tb/tb_vx_mem_line_bridge.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vx_mem_line_bridge_if.sv
// rtl/vx_mem_line_bridge_if.sv - Line request/response and word bus signal bundle for vx_mem_line_bridge
interface vx_mem_line_bridge_if #(
    parameter int LINE_W = 512,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 26,
    parameter int TAG_W  = 8
);
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_req_rw;
    logic [LINE_W/8-1:0]   mem_req_byteen;
    logic [ADDR_W-1:0]     mem_req_addr;
    logic [LINE_W-1:0]     mem_req_data;
    logic [TAG_W-1:0]      mem_req_tag;

    logic                  mem_rsp_valid;
    logic                  mem_rsp_ready;
    logic [LINE_W-1:0]     mem_rsp_data;
    logic [TAG_W-1:0]      mem_rsp_tag;

    logic                  bus_ren;
    logic                  bus_wen;
    logic [31:0]           bus_addr;
    logic [WORD_W-1:0]     bus_wdata;
    logic [WORD_W/8-1:0]   bus_strobe;
    logic [WORD_W-1:0]     bus_rdata;
    logic                  bus_request_stall;

    // Bridge side: accepts line requests, masters the word bus.
    modport slave (
        input  mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
        input  mem_rsp_ready, bus_rdata, bus_request_stall,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        output bus_ren, bus_wen, bus_addr, bus_wdata, bus_strobe
    );

    // Environment side: issues line requests, serves the word bus.
    modport master (
        output mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
        output mem_rsp_ready, bus_rdata, bus_request_stall,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        input  bus_ren, bus_wen, bus_addr, bus_wdata, bus_strobe
    );
endinterface

// File: rtl/vx_mem_line_bridge.sv
// rtl/vx_mem_line_bridge.sv - Line-to-word memory bridge; optional VX_MEM_BRIDGE_SKIP_EN skips strobe-less write words
module vx_mem_line_bridge #(
    parameter int LINE_W = 512,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 26,
    parameter int TAG_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    vx_mem_line_bridge_if.slave br,
    output logic                busy
);
    localparam int WORDS = LINE_W / WORD_W;
    localparam int SB    = WORD_W / 8;
    localparam int IDX_W = $clog2(WORDS);
    localparam int BA_W  = ADDR_W + IDX_W + 2;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic                rw_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LINE_W-1:0]   data_q;
    logic [LINE_W/8-1:0] byteen_q;
    logic [TAG_W-1:0]    tag_q;
    logic [LINE_W-1:0]   line_q;
    logic                ren_q;
    logic                wen_q;
    logic                rsp_valid_q;
    logic                busy_q;
    logic                ready_q;

    logic [BA_W-1:0]     byte_addr;
    logic                word_done;
    logic                last_word;

    assign byte_addr = {addr_q, idx, 2'b00};
    assign word_done = (ren_q || wen_q) && !br.bus_request_stall;
    assign last_word = (idx == LAST);

    assign br.mem_req_ready = ready_q;
    assign br.mem_rsp_valid = rsp_valid_q;
    assign br.mem_rsp_data  = line_q;
    assign br.mem_rsp_tag   = tag_q;
    assign br.bus_ren       = ren_q;
    assign br.bus_wen       = wen_q;
    assign br.bus_addr      = 32'(byte_addr);
    assign br.bus_wdata     = data_q[idx*WORD_W +: WORD_W];
    assign br.bus_strobe    = byteen_q[idx*SB +: SB];
    assign busy             = busy_q;

`ifdef VX_MEM_BRIDGE_SKIP_EN
    logic             first_found;
    logic             next_found;
    logic [IDX_W-1:0] first_idx;
    logic [IDX_W-1:0] next_idx;

    // Lowest enabled word of the incoming request and the next enabled word after the current one
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int k = WORDS - 1; k >= 0; k--) begin
            if (|br.mem_req_byteen[k*SB +: SB]) begin
                first_found = 1'b1;
                first_idx   = IDX_W'(k);
            end
            if (k > int'(idx) && |byteen_q[k*SB +: SB]) begin
                next_found = 1'b1;
                next_idx   = IDX_W'(k);
            end
        end
    end
`endif

    // Request capture, word sequencing, read assembly and response hand-off
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            idx         <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            byteen_q    <= '0;
            tag_q       <= '0;
            line_q      <= '0;
            ren_q       <= 1'b0;
            wen_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (br.mem_req_valid) begin
                        rw_q     <= br.mem_req_rw;
                        addr_q   <= br.mem_req_addr;
                        data_q   <= br.mem_req_data;
                        byteen_q <= br.mem_req_byteen;
                        tag_q    <= br.mem_req_tag;
                        state    <= ACCESS;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        if (br.mem_req_rw) begin
`ifdef VX_MEM_BRIDGE_SKIP_EN
                            idx   <= first_idx;
                            wen_q <= first_found;
`else
                            idx   <= '0;
                            wen_q <= 1'b1;
`endif
                        end else begin
                            idx   <= '0;
                            ren_q <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (!(ren_q || wen_q)) begin
                        // Write with nothing enabled: nothing to issue.
                        state   <= IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        idx     <= '0;
                    end else if (word_done) begin
                        if (ren_q) begin
                            line_q[idx*WORD_W +: WORD_W] <= br.bus_rdata;
                            if (last_word) begin
                                state       <= RESP;
                                ren_q       <= 1'b0;
                                rsp_valid_q <= 1'b1;
                                idx         <= '0;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end else begin
`ifdef VX_MEM_BRIDGE_SKIP_EN
                            if (next_found) begin
                                idx <= next_idx;
                            end else begin
`else
                            if (!last_word) begin
                                idx <= idx + 1'b1;
                            end else begin
`endif
                                state   <= IDLE;
                                wen_q   <= 1'b0;
                                busy_q  <= 1'b0;
                                ready_q <= 1'b1;
                                idx     <= '0;
                            end
                        end
                    end
                end
                RESP: begin
                    if (br.mem_rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        ready_q     <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vx_mem_line_bridge.sv
// tb/tb_vx_mem_line_bridge.sv - Self-checking bench for vx_mem_line_bridge
module tb_vx_mem_line_bridge;
    localparam int LINE_W = 512;
    localparam int WORD_W = 32;
    localparam int ADDR_W = 26;
    localparam int TAG_W  = 8;
    localparam int WORDS  = LINE_W / WORD_W;
`ifdef VX_MEM_BRIDGE_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk;
    logic reset;
    logic busy;
    int   tests;
    int   fails;
    logic [WORD_W-1:0] rd_line [WORDS];

    vx_mem_line_bridge_if #(.LINE_W(LINE_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W)) bif ();

    vx_mem_line_bridge #(.LINE_W(LINE_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .br    (bif),
        .busy  (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One line transaction: the model lists which words must appear on the bus, in order,
    // and derives the completion cycle from word count plus stalled cycles.
    task automatic run_txn(input bit rw, input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] data,
                           input logic [LINE_W/8-1:0] be, input logic [TAG_W-1:0] tag, input int pct,
                           input int fix_word, input int fix_len, input int rsp_delay, input string name);
        int exp_idx[$];
        int cycle;
        int stalls;
        int fix_left;
        int n;
        int head;
        int exp_end;
        bit done;
        bit stall;
        logic [LINE_W-1:0] exp_line;
        logic [31:0] exp_a;
        logic [3:0] kk;
        for (int k = 0; k < WORDS; k++) begin
            if (!rw || !SKIP || be[k*4 +: 4] != 4'h0) exp_idx.push_back(k);
            exp_line[k*WORD_W +: WORD_W] = rd_line[k];
        end
        n = exp_idx.size();
        cycle = 0;
        stalls = 0;
        fix_left = fix_len;
        done = 1'b0;

        @(negedge clk);
        tests++;
        if (bif.mem_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s req_ready_idle: got %b expected 1", name, bif.mem_req_ready);
        end
        bif.mem_req_valid  = 1'b1;
        bif.mem_req_rw     = rw;
        bif.mem_req_addr   = addr;
        bif.mem_req_data   = data;
        bif.mem_req_byteen = be;
        bif.mem_req_tag    = tag;
        @(posedge clk);
        #1;
        bif.mem_req_valid = 1'b0;

        while (!done && cycle < 400) begin
            @(negedge clk);
            cycle++;
            if (bif.mem_rsp_valid) begin
                done = 1'b1;
            end else if (bif.bus_ren || bif.bus_wen) begin
                head = (exp_idx.size() > 0) ? exp_idx[0] : 0;
                kk = 4'(head);
                exp_a = {addr, kk, 2'b00};
                tests++;
                if (exp_idx.size() == 0 || bif.bus_ren !== !rw || bif.bus_wen !== rw || bif.bus_addr !== exp_a ||
                    (rw && (bif.bus_wdata !== data[head*WORD_W +: WORD_W] || bif.bus_strobe !== be[head*4 +: 4]))) begin
                    fails++;
                    $display("FAIL %s bus_word: cycle %0d got ren=%b wen=%b addr=%h wdata=%h strobe=%h, expected word %0d addr=%h wdata=%h strobe=%h (%0d words left)",
                             name, cycle, bif.bus_ren, bif.bus_wen, bif.bus_addr, bif.bus_wdata, bif.bus_strobe,
                             head, exp_a, data[head*WORD_W +: WORD_W], be[head*4 +: 4], exp_idx.size());
                end
                if (head == fix_word && fix_left > 0) begin
                    stall = 1'b1;
                    fix_left--;
                end else begin
                    stall = ($urandom_range(99) < pct);
                end
                bif.bus_request_stall = stall;
                bif.bus_rdata = rd_line[head];
                if (stall) stalls++;
                else if (exp_idx.size() > 0) void'(exp_idx.pop_front());
            end else begin
                bif.bus_request_stall = 1'($urandom_range(1));
                if (!busy) done = 1'b1;
            end
        end
        bif.bus_request_stall = 1'b0;

        tests++;
        if (!done) begin
            fails++;
            $display("FAIL %s timeout: no completion after %0d cycles", name, cycle);
        end
        tests++;
        if (exp_idx.size() != 0) begin
            fails++;
            $display("FAIL %s words_missing: got %0d of %0d words", name, n - exp_idx.size(), n);
        end
        if (rw) begin
            exp_end = ((n == 0) ? 1 : n) + stalls + 1;
            tests++;
            if (bif.mem_rsp_valid !== 1'b0) begin
                fails++;
                $display("FAIL %s write_rsp: got mem_rsp_valid=%b expected 0", name, bif.mem_rsp_valid);
            end
            tests++;
            if (cycle != exp_end) begin
                fails++;
                $display("FAIL %s write_idle_cycle: got %0d expected %0d", name, cycle, exp_end);
            end
            tests++;
            if (bif.mem_req_ready !== 1'b1) begin
                fails++;
                $display("FAIL %s write_ready: got %b expected 1", name, bif.mem_req_ready);
            end
        end else begin
            exp_end = n + stalls + 1;
            tests++;
            if (cycle != exp_end) begin
                fails++;
                $display("FAIL %s rsp_cycle: got %0d expected %0d", name, cycle, exp_end);
            end
            tests++;
            if (bif.mem_rsp_data !== exp_line) begin
                fails++;
                $display("FAIL %s rsp_data: got %h expected %h", name, bif.mem_rsp_data, exp_line);
            end
            tests++;
            if (bif.mem_rsp_tag !== tag) begin
                fails++;
                $display("FAIL %s rsp_tag: got %h expected %h", name, bif.mem_rsp_tag, tag);
            end
            for (int i = 0; i < rsp_delay; i++) begin
                @(negedge clk);
                tests++;
                if (bif.mem_rsp_valid !== 1'b1 || bif.mem_rsp_data !== exp_line || bif.mem_rsp_tag !== tag ||
                    bif.mem_req_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL %s rsp_hold: cycle %0d got valid=%b tag=%h ready=%b data_ok=%b expected valid=1 tag=%h ready=0 data_ok=1",
                             name, i, bif.mem_rsp_valid, bif.mem_rsp_tag, bif.mem_req_ready,
                             bif.mem_rsp_data === exp_line, tag);
                end
            end
            bif.mem_rsp_ready = 1'b1;
            @(negedge clk);
            bif.mem_rsp_ready = 1'b0;
            tests++;
            if (bif.mem_rsp_valid !== 1'b0 || bif.mem_req_ready !== 1'b1 || busy !== 1'b0) begin
                fails++;
                $display("FAIL %s rsp_release: got valid=%b ready=%b busy=%b expected 0 1 0",
                         name, bif.mem_rsp_valid, bif.mem_req_ready, busy);
            end
        end
    endtask

    task automatic test_reset();
        tests++;
        if (bif.mem_req_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready_busy: got ready=%b busy=%b expected 1 0", bif.mem_req_ready, busy);
        end
        tests++;
        if (bif.bus_ren !== 1'b0 || bif.bus_wen !== 1'b0 || bif.mem_rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_strobes: got ren=%b wen=%b rsp_valid=%b expected 0 0 0",
                     bif.bus_ren, bif.bus_wen, bif.mem_rsp_valid);
        end
        tests++;
        if (bif.mem_rsp_data !== '0 || bif.mem_rsp_tag !== '0) begin
            fails++;
            $display("FAIL reset_line_tag: got tag=%h data=%h expected zero", bif.mem_rsp_tag, bif.mem_rsp_data);
        end
    endtask

    task automatic test_read_basic();
        for (int k = 0; k < WORDS; k++) rd_line[k] = 32'h1000 + 32'(k);
        run_txn(1'b0, 26'h10, '0, '1, 8'h5A, 0, -1, 0, 0, "read_basic");
    endtask

    task automatic test_write_basic();
        logic [LINE_W-1:0] d;
        for (int k = 0; k < WORDS; k++) d[k*WORD_W +: WORD_W] = 32'(k);
        run_txn(1'b1, 26'h2, d, '1, 8'h11, 0, -1, 0, 0, "write_basic");
    endtask

    task automatic test_stall();
        for (int k = 0; k < WORDS; k++) rd_line[k] = $urandom;
        run_txn(1'b0, 26'h10, '0, '1, 8'h33, 0, 5, 3, 0, "read_stall");
    endtask

    task automatic test_sparse_write();
        logic [LINE_W-1:0] d;
        for (int k = 0; k < WORDS; k++) d[k*WORD_W +: WORD_W] = $urandom;
        run_txn(1'b1, 26'h3F, d, 64'h0000_0000_0000_F000, 8'h44, 0, -1, 0, 0, "write_sparse");
        run_txn(1'b1, 26'h40, d, '0, 8'h45, 0, -1, 0, 0, "write_zero");
    endtask

    task automatic test_rsp_backpressure();
        for (int k = 0; k < WORDS; k++) rd_line[k] = $urandom;
        run_txn(1'b0, 26'h155, '0, '1, 8'hC3, 0, -1, 0, 5, "rsp_backpressure");
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < WORDS; k++) rd_line[k] = $urandom;
        @(negedge clk);
        bif.mem_req_valid = 1'b1;
        bif.mem_req_rw    = 1'b0;
        bif.mem_req_addr  = 26'h10;
        bif.mem_req_tag   = 8'h77;
        @(posedge clk);
        #1;
        bif.mem_req_valid = 1'b0;
        bif.bus_request_stall = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            bif.bus_rdata = rd_line[c-1];
        end
        tests++;
        if (bif.bus_ren !== 1'b1 || bif.bus_addr !== 32'h41C) begin
            fails++;
            $display("FAIL reset_mid_word7: got ren=%b addr=%h expected 1 0000041c", bif.bus_ren, bif.bus_addr);
        end
        reset = 1'b0;
        #1;
        tests++;
        if (bif.bus_ren !== 1'b0 || busy !== 1'b0 || bif.mem_rsp_valid !== 1'b0 || bif.mem_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_async: got ren=%b busy=%b rsp_valid=%b ready=%b expected 0 0 0 1",
                     bif.bus_ren, busy, bif.mem_rsp_valid, bif.mem_req_ready);
        end
        tests++;
        if (bif.mem_rsp_tag !== '0 || bif.mem_rsp_data !== '0) begin
            fails++;
            $display("FAIL reset_mid_regs: got tag=%h data=%h expected zero", bif.mem_rsp_tag, bif.mem_rsp_data);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            tests++;
            if (bif.bus_ren || bif.bus_wen || bif.mem_rsp_valid || busy) begin
                fails++;
                $display("FAIL reset_mid_quiet: cycle %0d got ren=%b wen=%b rsp_valid=%b busy=%b expected all 0",
                         c, bif.bus_ren, bif.bus_wen, bif.mem_rsp_valid, busy);
            end
        end
    endtask

    task automatic test_random();
        logic [LINE_W-1:0]   d;
        logic [LINE_W/8-1:0] be;
        int mode;
        for (int t = 0; t < 24; t++) begin
            for (int k = 0; k < WORDS; k++) begin
                d[k*WORD_W +: WORD_W] = $urandom;
                rd_line[k] = $urandom;
            end
            mode = $urandom_range(3);
            for (int k = 0; k < WORDS; k++) begin
                case (mode)
                    0: be[k*4 +: 4] = 4'hF;
                    1: be[k*4 +: 4] = 4'($urandom);
                    2: be[k*4 +: 4] = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
                    default: be[k*4 +: 4] = 4'h0;
                endcase
            end
            run_txn(1'($urandom_range(1)), 26'($urandom), d, be, 8'($urandom),
                    $urandom_range(40), -1, 0, $urandom_range(3), $sformatf("random_%0d", t));
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        bif.mem_req_valid     = 1'b0;
        bif.mem_req_rw        = 1'b0;
        bif.mem_req_addr      = '0;
        bif.mem_req_data      = '0;
        bif.mem_req_byteen    = '0;
        bif.mem_req_tag       = '0;
        bif.mem_rsp_ready     = 1'b0;
        bif.bus_rdata         = '0;
        bif.bus_request_stall = 1'b0;
        for (int k = 0; k < WORDS; k++) rd_line[k] = '0;
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b1;
        test_read_basic();
        test_write_basic();
        test_stall();
        test_sparse_write();
        test_rsp_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
